// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
// The optional subtract feature is controlled by the SERIAL_ADD_SUB_EN macro.
package serial_add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width: clog2 of the step count, never below one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / NIBBLE);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Operand/result handshake bundle for serial_nibble_adder.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_nibble_adder_if #(parameter int WIDTH = 16);

  // valid/ready: a transfer happens on a rising edge where both are high;
  // the source holds its data stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, S, C
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, S, C
  );

endinterface

// File: rtl/serial_nibble_adder_nibble.sv
// Combinational 4-bit adder slice with carry in and carry out.
module nibble_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder built from one nibble slice, one nibble per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port and A - B support.
module serial_nibble_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_nibble_adder_if.slave bus,
  output state_t               dbg_state
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next, s_q;
  logic             carry, c_q;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [3:0]       b_nib, sum_nib;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign b_nib = sub_q ? ~b_sh[3:0] : b_sh[3:0];
`else
  assign b_nib = b_sh[3:0];
`endif

  nibble_adder u_slice (
    .A    (a_sh[3:0]),
    .B    (b_nib),
    .Cin  (carry),
    .S    (sum_nib),
    .Cout (cout)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom.
  assign r_next = (r_sh >> NIBBLE) | (WIDTH'(sum_nib) << (WIDTH - NIBBLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == CW'(N - 1)) begin
        last     = 1'b1;
        state_nx = DONE;
      end
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= bus.sub;
      carry <= bus.sub;
`else
      carry <= 1'b0;
`endif
    end else if (state == RUN) begin
      a_sh  <= a_sh >> NIBBLE;
      b_sh  <= b_sh >> NIBBLE;
      r_sh  <= r_next;
      carry <= cout;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        s_q <= r_next;
        c_q <= cout;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.C         = c_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder: directed cases plus random operands vs a model.
module tb_serial_nibble_adder;
  import serial_add_pkg::*;

  localparam int W = 16;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     cyc;
  int     acc_cyc;
  int     n_checks;
  int     n_pass;

  logic [W:0] exp_q[$];

  serial_nibble_adder_if #(.WIDTH(W)) bus ();

  serial_nibble_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: plain WIDTH+1 bit arithmetic; subtract is A + ~B + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W:0] t;
    if (s) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   t = {1'b0, a} + {1'b0, b};
    return t;
  endfunction

  // Scoreboard: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("extra_result", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("result_S", 32'(bus.S), 32'(e[W-1:0]));
        check("result_C", 32'(bus.C), 32'(e[W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit push);
    int g;
`ifndef SERIAL_ADD_SUB_EN
    s = 1'b0;
`endif
    @(posedge clk); #1;
    bus.A = a;
    bus.B = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
`endif
    bus.in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back(model(a, b, s));
  endtask

  task automatic wait_result(output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         lat;
    int         acc1;
    int         stall;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    bit         rs;

    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_S", 32'(bus.S), 32'd0);
    check("rst_C", 32'(bus.C), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Basic add with latency check.
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_result(lat);
    check("lat_basic", 32'(lat), 32'd4);
    check("basic_S", 32'(bus.S), 32'h5555);
    check("basic_C", 32'(bus.C), 32'd0);

    send(16'h00FF, 16'h0001, 1'b0, 1'b1);
    wait_result(lat);
    check("xnib_S", 32'(bus.S), 32'h0100);
    check("xnib_C", 32'(bus.C), 32'd0);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_result(lat);
    check("wrap_S", 32'(bus.S), 32'h0000);
    check("wrap_C", 32'(bus.C), 32'd1);

    // Backpressure: result holds while new operands are offered.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b0, 1'b1);
    e = model(16'hABCD, 16'h1111, 1'b0);
    wait_result(lat);
    check("lat_bp", 32'(lat), 32'd4);
    @(posedge clk); #1;
    bus.A = 16'h0F00;
    bus.B = 16'h00F0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_S", 32'(bus.S), 32'(e[W-1:0]));
      check("bp_C", 32'(bus.C), 32'(e[W]));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_out_valid_fall", 32'(bus.out_valid), 32'd0);
    check("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
    check("bp_S_hold", 32'(bus.S), 32'(e[W-1:0]));
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_no_take", 32'(dbg_state), 32'(IDLE));
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset two cycles into RUN discards the operation.
    send(16'h5555, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_S", 32'(bus.S), 32'd0);
    check("mid_rst_C", 32'(bus.C), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", 32'(dbg_state), 32'(IDLE));
    send(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    wait_result(lat);
    check("post_rst_S", 32'(bus.S), 32'h1010);
    check("post_rst_C", 32'(bus.C), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_result(lat);
    check("sub_pos_S", 32'(bus.S), 32'h0002);
    check("sub_pos_C", 32'(bus.C), 32'd1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result(lat);
    check("sub_neg_S", 32'(bus.S), 32'hFFFE);
    check("sub_neg_C", 32'(bus.C), 32'd0);
`endif

    // Back-to-back: in_valid held, out_ready tied high.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b1);
    acc1 = acc_cyc;
    send(16'h8000, 16'h8001, 1'b0, 1'b1);
    check("b2b_interval", 32'(acc_cyc - acc1), 32'd6);
    wait_result(lat);
    check("b2b_S", 32'(bus.S), 32'h0001);
    check("b2b_C", 32'(bus.C), 32'd1);

    // Random operands with random output stalls.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      stall = $urandom_range(0, 3);
      @(posedge clk); #1;
      bus.out_ready = (stall == 0);
      send(ra, rb, rs, 1'b1);
      wait_result(lat);
      check("rand_lat", 32'(lat), 32'd4);
      repeat (stall) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(dbg_state), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
